// File: rtl/miner_nonce_sched.sv
// miner_nonce_sched: interleaved nonce sweep across hash lanes with round-robin golden-nonce collection FIFO.
module miner_nonce_sched #(
  parameter int LANES      = 4,
  parameter int NONCE_W    = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LID_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     work_start,
  input  logic [NONCE_W-1:0]       nonce_base,
  input  logic [LANES-1:0]         lane_en,
  output logic [LANES-1:0]         lane_run,
  output logic [LANES*NONCE_W-1:0] lane_nonce,
  input  logic [LANES-1:0]         hit_valid,
  input  logic [LANES*NONCE_W-1:0] hit_nonce,
  output logic                     res_valid,
  output logic [NONCE_W-1:0]       res_nonce,
  output logic [LID_W-1:0]         res_lane,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);
  localparam int SW = NONCE_W - $clog2(LANES);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] k_q, k_d;
  logic [NONCE_W-1:0] cur_q, cur_d;
  logic [LANES-1:0] en_q, en_d, hold_v_q, hold_v_d;
  logic [NONCE_W-1:0] hold_n_q [LANES];
  logic [NONCE_W-1:0] hold_n_d [LANES];
  logic [LID_W-1:0] ptr_q, ptr_d, gnt;
  logic gnt_v, push, pop, full, ovf_q, ovf_d;
  logic [NONCE_W+LID_W-1:0] mem_q [FIFO_DEPTH];
  logic [NONCE_W+LID_W-1:0] mem_d [FIFO_DEPTH];
  logic [NONCE_W+LID_W-1:0] head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign overflow  = ovf_q;
  assign lane_run  = {LANES{busy}} & en_q;
  assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign res_valid = cnt_q != '0;
  assign head      = mem_q[rd_q];
  assign res_nonce = res_valid ? head[NONCE_W+LID_W-1:LID_W] : '0;
  assign res_lane  = res_valid ? head[LID_W-1:0] : '0;
  assign pop       = res_valid & res_ready;
  assign push      = gnt_v & (!full | pop);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_nonce[i*NONCE_W +: NONCE_W] = lane_run[i] ? cur_q + NONCE_W'(i) : '0;
  end
  // Scan from the highest offset down so the nearest full hold at or after ptr wins.
  always_comb begin
    gnt   = '0;
    gnt_v = 1'b0;
    for (int j = LANES - 1; j >= 0; j--)
      if (hold_v_q[(int'(ptr_q) + j) % LANES]) begin
        gnt   = LID_W'((int'(ptr_q) + j) % LANES);
        gnt_v = 1'b1;
      end
  end
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cur_d    = cur_q;
    en_d     = en_q;
    hold_v_d = hold_v_q;
    hold_n_d = hold_n_q;
    ptr_d    = ptr_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = ovf_q;
    if (state_q == RUN) begin
      k_d     = k_q + 1'b1;
      cur_d   = cur_q + NONCE_W'(LANES);
      state_d = &k_q ? DONE : RUN;
    end
    if (push) begin
      mem_d[wr_q] = {hold_n_q[gnt], gnt};
      wr_d        = wr_q + 1'b1;
      ptr_d       = LID_W'((int'(gnt) + 1) % LANES);
    end
    for (int i = 0; i < LANES; i++)
      if (hit_valid[i] && (!hold_v_q[i] || (push && gnt == LID_W'(i)))) begin
        hold_v_d[i] = 1'b1;
        hold_n_d[i] = hit_nonce[i*NONCE_W +: NONCE_W];
      end else if (hit_valid[i]) ovf_d = 1'b1;
      else if (push && gnt == LID_W'(i)) hold_v_d[i] = 1'b0;
    if (work_start) begin
      state_d  = RUN;
      k_d      = '0;
      cur_d    = nonce_base;
      en_d     = lane_en;
      hold_v_d = '0;
      wr_d     = '0;
      rd_d     = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cur_q    <= '0;
      en_q     <= '0;
      hold_v_q <= '0;
      ptr_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < LANES; i++) hold_n_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cur_q    <= cur_d;
      en_q     <= en_d;
      hold_v_q <= hold_v_d;
      hold_n_q <= hold_n_d;
      ptr_q    <= ptr_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
